// File: rtl/analogue_pkg.sv
// rtl/analogue_pkg.sv - shared types and helpers for the analogue filter library
package analogue_pkg;

  typedef enum logic [1:0] {
    ST_IDLE    = 2'd0,
    ST_LOAD    = 2'd1,
    ST_PENDING = 2'd2,
    ST_FLUSH   = 2'd3
  } state_t;

  // Smallest address width that can reach all 2N+1 coefficient words.
  function automatic int min_addr_width(input int n);
    return (2 * n + 1 > 1) ? $clog2(2 * n + 1) : 1;
  endfunction

  function automatic logic [63:0] unity_coeff(input int q);
    return 64'd1 << q;
  endfunction

endpackage

// File: rtl/coeff_bank.sv
// rtl/coeff_bank.sv - coefficient register file with write port and parallel load
module coeff_bank
  import analogue_pkg::*;
#(
  parameter int                     WORDS       = 5,
  parameter int                     COEFF_WIDTH = 16,
  parameter int                     ADDR_WIDTH  = 3,
  parameter logic [COEFF_WIDTH-1:0] RESET_WORD  = '0
) (
  input  logic                           clk,
  input  logic                           rst_n,
  input  logic                           wr_en,
  input  logic [ADDR_WIDTH-1:0]          wr_addr,
  input  logic [COEFF_WIDTH-1:0]         wr_data,
  input  logic                           load_en,
  input  logic [WORDS*COEFF_WIDTH-1:0]   load_data,
  output logic [WORDS*COEFF_WIDTH-1:0]   flat_data
);

  logic [COEFF_WIDTH-1:0] mem [WORDS];

  // Word 0 resets to RESET_WORD so the bank powers up as a pass-through.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      for (int i = 0; i < WORDS; i++) mem[i] <= (i == 0) ? RESET_WORD : '0;
    end else if (load_en) begin
      for (int i = 0; i < WORDS; i++) mem[i] <= load_data[i*COEFF_WIDTH +: COEFF_WIDTH];
    end else if (wr_en) begin
      for (int i = 0; i < WORDS; i++) begin
        if (int'(wr_addr) == i) mem[i] <= wr_data;
      end
    end
  end

  always_comb begin
    flat_data = '0;
    for (int i = 0; i < WORDS; i++) flat_data[i*COEFF_WIDTH +: COEFF_WIDTH] = mem[i];
  end

endmodule

// File: rtl/iir_coeff_loader.sv
// rtl/iir_coeff_loader.sv - shadow/active coefficient loader with sample-aligned commit
module iir_coeff_loader
  import analogue_pkg::*;
#(
  parameter int N            = 2,
  parameter int COEFF_WIDTH  = 16,
  parameter int Q            = 14,
  parameter int FLUSH_CYCLES = 4,
  parameter int ADDR_WIDTH   = 3
) (
  input  logic                         clk,
  input  logic                         rst_n,
  input  logic                         wr_valid,
  output logic                         wr_ready,
  input  logic [ADDR_WIDTH-1:0]        wr_addr,
  input  logic [COEFF_WIDTH-1:0]       wr_data,
  input  logic                         commit,
  input  logic                         commit_flush,
  input  logic                         sample_tick,
  output logic [COEFF_WIDTH*(N+1)-1:0] packed_b_coeffs,
  output logic [COEFF_WIDTH*N-1:0]     packed_a_coeffs,
  output logic                         filter_rst_n,
  output logic                         commit_done,
  output logic                         addr_err
);

  localparam int WORDS = 2 * N + 1;
  localparam logic [COEFF_WIDTH-1:0] UNITY = COEFF_WIDTH'(unity_coeff(Q));
  localparam int CNT_W = (FLUSH_CYCLES > 1) ? $clog2(FLUSH_CYCLES) : 1;
  localparam logic [CNT_W-1:0] CNT_INIT = CNT_W'(FLUSH_CYCLES - 1);

  state_t                      state, state_d;
  logic                        flush_q, done_pend, commit_done_q, filter_rst_q, addr_err_q;
  logic [CNT_W-1:0]            cnt;
  logic                        wr_fire, addr_bad, commit_fire, load_active;
  logic [WORDS*COEFF_WIDTH-1:0] shadow_flat, active_flat;

  assign wr_ready    = (state == ST_IDLE) || (state == ST_LOAD);
  assign wr_fire     = wr_valid && wr_ready;
  assign addr_bad    = int'(wr_addr) > 2 * N;
  assign commit_fire = commit && wr_ready;
  assign load_active = (state == ST_PENDING) && sample_tick;

  always_comb begin
    state_d = state;
    case (state)
      ST_IDLE, ST_LOAD: begin
        if (commit_fire)  state_d = ST_PENDING;
        else if (wr_fire) state_d = ST_LOAD;
      end
      ST_PENDING: if (sample_tick) state_d = flush_q ? ST_FLUSH : ST_IDLE;
      ST_FLUSH:   if (cnt == '0) state_d = ST_IDLE;
      default:    state_d = ST_IDLE;
    endcase
  end

  // A bad write in the commit cycle belongs to the new set, so it wins over the clear.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state         <= ST_IDLE;
      flush_q       <= 1'b0;
      done_pend     <= 1'b0;
      commit_done_q <= 1'b0;
      filter_rst_q  <= 1'b1;
      addr_err_q    <= 1'b0;
      cnt           <= '0;
    end else begin
      state         <= state_d;
      done_pend     <= 1'b0;
      commit_done_q <= done_pend;
      if (commit_fire) begin
        flush_q    <= commit_flush;
        addr_err_q <= 1'b0;
      end
      if (wr_fire && addr_bad) addr_err_q <= 1'b1;
      if (load_active) begin
        if (flush_q) begin
          filter_rst_q <= 1'b0;
          cnt          <= CNT_INIT;
        end else begin
          done_pend <= 1'b1;
        end
      end
      if (state == ST_FLUSH) begin
        if (cnt == '0) begin
          filter_rst_q  <= 1'b1;
          commit_done_q <= 1'b1;
        end else begin
          cnt <= cnt - 1'b1;
        end
      end
    end
  end

  coeff_bank #(
    .WORDS(WORDS), .COEFF_WIDTH(COEFF_WIDTH), .ADDR_WIDTH(ADDR_WIDTH), .RESET_WORD(UNITY)
  ) u_shadow (
    .clk(clk), .rst_n(rst_n),
    .wr_en(wr_fire && !addr_bad), .wr_addr(wr_addr), .wr_data(wr_data),
    .load_en(1'b0), .load_data('0),
    .flat_data(shadow_flat)
  );

  coeff_bank #(
    .WORDS(WORDS), .COEFF_WIDTH(COEFF_WIDTH), .ADDR_WIDTH(ADDR_WIDTH), .RESET_WORD(UNITY)
  ) u_active (
    .clk(clk), .rst_n(rst_n),
    .wr_en(1'b0), .wr_addr('0), .wr_data('0),
    .load_en(load_active), .load_data(shadow_flat),
    .flat_data(active_flat)
  );

  assign packed_b_coeffs = active_flat[COEFF_WIDTH*(N+1)-1:0];
  assign packed_a_coeffs = active_flat[COEFF_WIDTH*WORDS-1:COEFF_WIDTH*(N+1)];
  assign filter_rst_n    = filter_rst_q;
  assign commit_done     = commit_done_q;
  assign addr_err        = addr_err_q;

endmodule

// File: doc/iir_coeff_loader.md
# iir_coeff_loader

Coefficient writer for the direct-form-I IIR filter in the analogue library. It accepts coefficient words over a valid/ready write port into a shadow bank. On a commit request it transfers the whole bank atomically into the packed `a`/`b` coefficient buses that drive the filter, aligned to a sample boundary. It can optionally hold the filter's delay lines in reset afterwards, so new coefficients never mix with stale state mid-sample.

## Interface
- `N`, 2: filter order; bank holds N+1 `b` words and N `a` words.
- `COEFF_WIDTH`, 16: coefficient width, signed.
- `Q`, 14: coefficient scale index; unity gain is 1<<Q.
- `FLUSH_CYCLES`, 4: length of the filter reset pulse on a flushing commit, ≥1.
- `ADDR_WIDTH`, 3: write address width, must satisfy 2^ADDR_WIDTH ≥ 2N+1.
- `clk` in 1: single clock for all logic.
- `rst_n` in 1: asynchronous, active-low reset.
- `wr_valid` in 1: write request.
- `wr_ready` out 1: write can be accepted.
- `wr_addr` in ADDR_WIDTH: address 0..N selects b[0..N]; N+1..2N selects a[0..N-1].
- `wr_data` in COEFF_WIDTH: coefficient word.
- `commit` in 1: single-cycle commit request.
- `commit_flush` in 1: sampled with `commit`; 1 requests a delay-line flush.
- `sample_tick` in 1: one-cycle strobe, asserted in the cycle the filter registers a sample.
- `packed_b_coeffs` out COEFF_WIDTH*(N+1): active b bank, b[t] at bits [COEFF_WIDTH*t +: COEFF_WIDTH].
- `packed_a_coeffs` out COEFF_WIDTH*N: active a bank, same packing.
- `filter_rst_n` out 1: active-low reset to the filter.
- `commit_done` out 1: one-cycle pulse when a commit completes.
- `addr_err` out 1: sticky flag for an out-of-range write; cleared by reset or by an accepted commit.

## Operation
- Reset values:
  - Shadow and active banks: b[0]=1<<Q, all other words 0 (unity pass-through).
  - `filter_rst_n`=1, `wr_ready`=1, `commit_done`=0, `addr_err`=0.
  - State is IDLE.
- States:
  - IDLE/LOAD: `wr_ready`=1. LOAD is entered on the first accepted write; IDLE and LOAD otherwise behave identically.
  - PENDING: `wr_ready`=0. Waiting for `sample_tick`.
  - FLUSH: `wr_ready`=0, `filter_rst_n`=0. Counts FLUSH_CYCLES cycles.
- Writes:
  - A write is accepted when `wr_valid`&&`wr_ready`. The shadow word updates at that edge.
  - If `wr_addr`>2N, the data is dropped and `addr_err` is set.
  - The active bank is never touched by a write.
- Commits:
  - A commit is accepted in IDLE or LOAD. The next state is PENDING, and `commit_flush` is latched.
  - If a write is accepted in the same cycle as the commit, that write is included in the committed set.
  - `commit` is ignored in PENDING and FLUSH.
- In PENDING:
  - On the first edge where `sample_tick`=1, active ← shadow.
  - Without flush: pulse `commit_done` in the next cycle and return to IDLE.
  - With flush: go to FLUSH.
- In FLUSH:
  - `filter_rst_n` is low for exactly FLUSH_CYCLES cycles.
  - In the cycle `filter_rst_n` returns high, pulse `commit_done` and go to IDLE.
- Width rules: data is stored verbatim with no sign handling; negation of `a` is the filter's job. Address decode is unsigned.
- Reset mid-operation (any state): all registers take their reset values immediately. A pending commit is discarded.

## Timing
- Write to shadow: 1 cycle. Shadow to active: 0 cycles after the qualifying `sample_tick` edge. The active bank changes on exactly one edge, never partially.
- A `sample_tick` in the same cycle as commit acceptance does not qualify. The earliest qualifying tick is one cycle later.
- Minimum commit→`commit_done` latency:
  - Without flush: 3 cycles (tick in the cycle after commit).
  - With flush: FLUSH_CYCLES+2.
- `filter_rst_n` is registered and glitch-free. It deasserts synchronously to `clk`.
- The `wr_ready` deassertion is registered. It goes low in the cycle after commit acceptance.

## Structure
- A shared `analogue_pkg` holds:
  - the state encoding constants;
  - a function mapping N to the minimum ADDR_WIDTH;
  - the unity-coefficient constant expression (1<<Q).
- One sub-module, `coeff_bank`: an (2N+1)×COEFF_WIDTH register file with a write port and a parallel load/flat output. It is instantiated twice, as shadow and active.

## Test plan
- **Reset defaults:** release reset → `packed_b_coeffs`=0x0000_0000_4000, `packed_a_coeffs`=0, `filter_rst_n`=1.
- **Plain commit:** write b0=0x1000, b1=0x2000, b2=0x1000, a0=0xC000, a1=0x0800; commit without flush; tick 5 cycles later.
  - Outputs unchanged until the tick edge.
  - Then b=0x1000_2000_1000, a=0x0800_C000.
  - `commit_done` one cycle later.
- **Write and commit same cycle:** write b1=0x7FFF in the commit cycle → b1=0x7FFF after the tick. A `sample_tick` in the commit cycle is ignored.
- **Flushing commit:** commit with `commit_flush`=1, FLUSH_CYCLES=4.
  - `filter_rst_n` low for exactly 4 cycles after the tick edge.
  - `commit_done` in the cycle it rises.
  - `wr_ready` stays 0 throughout.
- **Bad address:** write to addr 7 → no bank change, `addr_err`=1. `addr_err` clears on the next accepted commit.
- **Reset mid-commit:** assert `rst_n` in PENDING and in FLUSH.
  - Active bank returns to unity, `filter_rst_n`=1 immediately.
  - A later tick causes no update.
